// File: rtl/glitch_free_mux.sv
// Registered N-channel mux whose select must be stable before it switches.
// Optional: GLITCH_FREE_MUX_BLANK_ZERO_EN drives z to zero during BLANK.
module glitch_free_mux #(
  parameter int WIDTH         = 1,
  parameter int N_CH          = 2,
  parameter int SEL_W         = 1,
  parameter int STABLE_CYCLES = 4,
  parameter int BLANK_CYCLES  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CH*WIDTH-1:0] din,
  input  logic [SEL_W-1:0]      sel,
  output logic [WIDTH-1:0]      z,
  output logic [SEL_W-1:0]      cur_sel,
  output logic                  switching,
  output logic                  sel_err
);

  localparam int NSEL = 1 << SEL_W;
  localparam logic [SEL_W:0] NCH_L = (SEL_W+1)'(N_CH);
  localparam logic [7:0] STB = 8'(STABLE_CYCLES);
  localparam logic [7:0] BLK = 8'(BLANK_CYCLES);

  typedef enum logic [1:0] {
    LOCKED,
    QUALIFY,
    BLANK
  } state_t;

  state_t           r_state;
  logic [SEL_W-1:0] r_cand;
  logic [SEL_W-1:0] r_cur_sel;
  logic [7:0]       r_cnt;
  logic [7:0]       r_bcnt;
  logic [WIDTH-1:0] r_z;
  logic             r_switching;
  logic             r_sel_err;

  logic [WIDTH-1:0] w_ch [NSEL];
  logic             w_valid;
  logic [7:0]       w_cnt_inc;
  logic [7:0]       w_bcnt_inc;

  // Unused select codes map to zero so the index is always in range.
  for (genvar i = 0; i < NSEL; i++) begin : g_ch
    if (i < N_CH) begin : g_v
      assign w_ch[i] = din[i*WIDTH +: WIDTH];
    end else begin : g_z
      assign w_ch[i] = '0;
    end
  end

  assign w_valid    = ({1'b0, sel} < NCH_L);
  assign w_cnt_inc  = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
  assign w_bcnt_inc = (r_bcnt == 8'hFF) ? r_bcnt : r_bcnt + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= LOCKED;
      r_cand      <= '0;
      r_cur_sel   <= '0;
      r_cnt       <= '0;
      r_bcnt      <= '0;
      r_z         <= '0;
      r_switching <= 1'b0;
      r_sel_err   <= 1'b0;
    end else begin
      r_sel_err <= !w_valid;
      unique case (r_state)
        LOCKED: begin
          r_z <= w_ch[r_cur_sel];
          if (w_valid && sel != r_cur_sel) begin
            r_cand <= sel;
            r_cnt  <= 8'd1;
            if (STB <= 8'd1) begin
              if (BLK == 8'd0) begin
                r_cur_sel <= sel;
                r_cnt     <= '0;
              end else begin
                r_state     <= BLANK;
                r_bcnt      <= '0;
                r_switching <= 1'b1;
              end
            end else begin
              r_state     <= QUALIFY;
              r_switching <= 1'b1;
            end
          end
        end
        QUALIFY: begin
          r_z <= w_ch[r_cur_sel];
          if (!w_valid || sel == r_cur_sel) begin
            r_state     <= LOCKED;
            r_cnt       <= '0;
            r_switching <= 1'b0;
          end else if (sel == r_cand) begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc >= STB) begin
              if (BLK == 8'd0) begin
                r_cur_sel   <= r_cand;
                r_cnt       <= '0;
                r_state     <= LOCKED;
                r_switching <= 1'b0;
              end else begin
                r_state <= BLANK;
                r_bcnt  <= '0;
              end
            end
          end else begin
            r_cand <= sel;
            r_cnt  <= 8'd1;
          end
        end
        BLANK: begin
`ifdef GLITCH_FREE_MUX_BLANK_ZERO_EN
          r_z <= '0;
`endif
          r_bcnt <= w_bcnt_inc;
          if (w_bcnt_inc >= BLK) begin
            r_cur_sel   <= r_cand;
            r_cnt       <= '0;
            r_bcnt      <= '0;
            r_state     <= LOCKED;
            r_switching <= 1'b0;
          end
        end
        default: begin
          r_state     <= LOCKED;
          r_switching <= 1'b0;
        end
      endcase
    end
  end

  assign z         = r_z;
  assign cur_sel   = r_cur_sel;
  assign switching = r_switching;
  assign sel_err   = r_sel_err;

endmodule

// File: tb/tb_glitch_free_mux.sv
// Bench for glitch_free_mux: vector table, corner sequences, random vs model.
// Three instances with different stable/blank settings share one clock.
module tb_glitch_free_mux;

`ifdef GLITCH_FREE_MUX_BLANK_ZERO_EN
  localparam bit ZERO_BLANK = 1'b1;
`else
  localparam bit ZERO_BLANK = 1'b0;
`endif

  localparam int NCH [3]  = '{3, 4, 5};
  localparam int W   [3]  = '{8, 4, 4};
  localparam int STB [3]  = '{4, 2, 1};
  localparam int BLK [3]  = '{1, 0, 3};
  localparam int SMAX [3] = '{3, 7, 7};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] din_v [3];
  logic [2:0]  sel_v [3];

  logic [7:0] z1;
  logic [1:0] cs1;
  logic [3:0] z2, z3;
  logic [2:0] cs2, cs3;
  logic       sw1, sw2, sw3, er1, er2, er3;

  logic [7:0] az   [3];
  logic [2:0] acs  [3];
  logic       asw  [3];
  logic       aerr [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  glitch_free_mux #(.WIDTH(8), .N_CH(3), .SEL_W(2),
    .STABLE_CYCLES(4), .BLANK_CYCLES(1)) u_d1 (
    .clk(clk), .reset(rst), .din(din_v[0][23:0]),
    .sel(sel_v[0][1:0]), .z(z1), .cur_sel(cs1),
    .switching(sw1), .sel_err(er1));

  glitch_free_mux #(.WIDTH(4), .N_CH(4), .SEL_W(3),
    .STABLE_CYCLES(2), .BLANK_CYCLES(0)) u_d2 (
    .clk(clk), .reset(rst), .din(din_v[1][15:0]),
    .sel(sel_v[1]), .z(z2), .cur_sel(cs2),
    .switching(sw2), .sel_err(er2));

  glitch_free_mux #(.WIDTH(4), .N_CH(5), .SEL_W(3),
    .STABLE_CYCLES(1), .BLANK_CYCLES(3)) u_d3 (
    .clk(clk), .reset(rst), .din(din_v[2][19:0]),
    .sel(sel_v[2]), .z(z3), .cur_sel(cs3),
    .switching(sw3), .sel_err(er3));

  assign az[0] = z1;
  assign az[1] = {4'b0, z2};
  assign az[2] = {4'b0, z3};
  assign acs[0] = {1'b0, cs1};
  assign acs[1] = cs2;
  assign acs[2] = cs3;
  assign asw[0] = sw1;
  assign asw[1] = sw2;
  assign asw[2] = sw3;
  assign aerr[0] = er1;
  assign aerr[1] = er2;
  assign aerr[2] = er3;

  // Reference: candidate run length and remaining blank edges, no states.
  typedef struct packed {
    int       cur;
    int       cand;
    int       run;
    int       blk_left;
    logic [7:0] z;
    bit       err;
    bit       sw;
  } mdl_t;

  mdl_t m [3];

  function automatic logic [7:0] chval(logic [63:0] d, int c, int w);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    return 8'((d >> (c * w)) & mask);
  endfunction

  function automatic mdl_t mstep(mdl_t cur_m, logic [63:0] d,
                                 int s, int k);
    mdl_t n;
    n = cur_m;
    n.err = (s >= NCH[k]);
    if (cur_m.blk_left > 0) begin
      if (ZERO_BLANK) n.z = '0;
      n.blk_left = cur_m.blk_left - 1;
      if (n.blk_left == 0) n.cur = cur_m.cand;
    end else begin
      n.z = chval(d, cur_m.cur, W[k]);
      if (s >= NCH[k] || s == cur_m.cur) begin
        n.run = 0;
      end else begin
        if (cur_m.run > 0 && s == cur_m.cand) begin
          n.run = cur_m.run + 1;
        end else begin
          n.run  = 1;
          n.cand = s;
        end
        if (n.run >= STB[k]) begin
          n.run = 0;
          if (BLK[k] == 0) n.cur = n.cand;
          else n.blk_left = BLK[k];
        end
      end
    end
    n.sw = (n.run > 0) || (n.blk_left > 0);
    return n;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called at a negedge with inputs already driven.
  task automatic step(input bit do_rst);
    rst = do_rst;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (do_rst) m[k] = '0;
      else m[k] = mstep(m[k], din_v[k], int'(sel_v[k]), k);
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("dut%0d_z", k), 64'(az[k]), 64'(m[k].z));
      chk($sformatf("dut%0d_cur_sel", k), 64'(acs[k]), 64'(m[k].cur));
      chk($sformatf("dut%0d_switching", k), 64'(asw[k]), 64'(m[k].sw));
      chk($sformatf("dut%0d_sel_err", k), 64'(aerr[k]), 64'(m[k].err));
    end
  endtask

  typedef struct {
    bit         rst;
    logic [1:0] sel;
    logic [7:0] z;
    logic [1:0] cs;
    bit         sw;
    bit         err;
  } vec_t;

  vec_t tbl [13];

  initial begin
    logic [7:0] zb;
    bit         saw;
    zb = ZERO_BLANK ? 8'h00 : 8'hA5;
    tbl[0]  = '{1'b1, 2'd0, 8'h00, 2'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 2'd0, 8'hA5, 2'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 2'd1, 8'hA5, 2'd0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 2'd1, 8'hA5, 2'd0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 2'd1, 8'hA5, 2'd0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 2'd1, 8'hA5, 2'd0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 2'd1, zb,    2'd1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 2'd1, 8'h5A, 2'd1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 2'd3, 8'h5A, 2'd1, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 2'd1, 8'h5A, 2'd1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 2'd0, 8'h5A, 2'd1, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 2'd3, 8'h5A, 2'd1, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 2'd1, 8'h5A, 2'd1, 1'b0, 1'b0};

    din_v[0] = 64'h3C5AA5;
    din_v[1] = 64'h9C3E;
    din_v[2] = 64'h7B4D2;
    for (int k = 0; k < 3; k++) begin
      sel_v[k] = '0;
      m[k] = '0;
    end
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      sel_v[0] = {1'b0, tbl[i].sel};
      step(tbl[i].rst);
      chk($sformatf("tbl%0d_z", i), 64'(z1), 64'(tbl[i].z));
      chk($sformatf("tbl%0d_cur_sel", i), 64'(cs1), 64'(tbl[i].cs));
      chk($sformatf("tbl%0d_switching", i), 64'(sw1), 64'(tbl[i].sw));
      chk($sformatf("tbl%0d_sel_err", i), 64'(er1), 64'(tbl[i].err));
    end

    // Glitch: three cycles of ch1 must never reach z or cur_sel.
    sel_v[0] = 3'd0;
    step(1'b1);
    step(1'b0);
    saw = 1'b0;
    sel_v[0] = 3'd1;
    for (int j = 0; j < 3; j++) begin
      step(1'b0);
      if (cs1 == 2'd1 || z1 == 8'h5A) saw = 1'b1;
    end
    sel_v[0] = 3'd0;
    step(1'b0);
    chk("glitch_leak", 64'(saw), 64'd0);
    chk("glitch_cur_sel", 64'(cs1), 64'd0);
    chk("glitch_switching", 64'(sw1), 64'd0);

    // Restart: ch2 for two samples, then ch1 held; ch2 never connects.
    sel_v[0] = 3'd2;
    step(1'b0);
    step(1'b0);
    sel_v[0] = 3'd1;
    for (int j = 0; j < 5; j++) begin
      step(1'b0);
      chk($sformatf("restart_cur_sel%0d", j), 64'(cs1),
          (j < 4) ? 64'd0 : 64'd1);
    end
    step(1'b0);
    chk("restart_z", 64'(z1), 64'h5A);

    // Out-of-range select pulses sel_err and leaves cur_sel alone.
    sel_v[0] = 3'd3;
    step(1'b0);
    chk("oor_err", 64'(er1), 64'd1);
    chk("oor_cur_sel", 64'(cs1), 64'd1);
    sel_v[0] = 3'd1;
    step(1'b0);
    chk("oor_err_clear", 64'(er1), 64'd0);

    // Reset during BLANK aborts the switch.
    sel_v[0] = 3'd0;
    for (int j = 0; j < 4; j++) step(1'b0);
    chk("blank_switching", 64'(sw1), 64'd1);
    step(1'b1);
    chk("rst_blank_z", 64'(z1), 64'd0);
    chk("rst_blank_cur_sel", 64'(cs1), 64'd0);
    chk("rst_blank_switching", 64'(sw1), 64'd0);
    step(1'b0);

    // Random select runs, data changes and occasional reset.
    for (int c = 0; c < 800; c++) begin
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(0, 99) < 30)
          sel_v[k] = 3'($urandom_range(0, SMAX[k]));
        if ($urandom_range(0, 99) < 10)
          din_v[k] = {$urandom(), $urandom()};
      end
      step($urandom_range(0, 99) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
